// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared ALU codes, ALUOp classes and sequencer state type
package alu_seq_pkg;

  localparam int CODE_W = 4;
  localparam int CNT_W  = 4;

  // ALU control codes produced by the decoder
  localparam logic [CODE_W-1:0] ALU_NOP  = 4'd0;
  localparam logic [CODE_W-1:0] ALU_MUL  = 4'd1;
  localparam logic [CODE_W-1:0] ALU_ADD  = 4'd2;
  localparam logic [CODE_W-1:0] ALU_SLL  = 4'd3;
  localparam logic [CODE_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [CODE_W-1:0] ALU_BEQ  = 4'd5;
  localparam logic [CODE_W-1:0] ALU_SUB  = 4'd6;
  localparam logic [CODE_W-1:0] ALU_BGE  = 4'd7;
  localparam logic [CODE_W-1:0] ALU_MATR = 4'd8;

  // Major operation classes carried on ALUOp
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } seq_state_e;

  // Down-counter preload for an op that must stay busy for lat cycles
  function automatic logic [CNT_W-1:0] lat_preload(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALUOp/funct decode; matrix op gated by ALU_SEQ_MATR_EN
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0]        alu_op,
  input  logic [1:0]        funct7,
  input  logic [2:0]        funct3,
  output logic [CODE_W-1:0] code,
  output logic              is_multi,
  output logic              illegal
);

  // Table lookup; anything not listed falls through to NOP flagged illegal
  always_comb begin
    code     = ALU_NOP;
    is_multi = 1'b0;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_LDST: code = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'd0:    code = ALU_BEQ;
          3'd5:    code = ALU_BGE;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_RTYPE: begin
        case ({funct7, funct3})
          5'b00000: code = ALU_ADD;
          5'b00100: code = ALU_XOR;
          5'b10000: code = ALU_SUB;
          5'b01000: begin
            code     = ALU_MUL;
            is_multi = 1'b1;
          end
`ifdef ALU_SEQ_MATR_EN
          5'b00001: begin
            code     = ALU_MATR;
            is_multi = 1'b1;
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_ITYPE: begin
        case (funct3)
          3'd1:    code = ALU_SLL;
          3'd0:    code = ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU control sequencer with multi-cycle stall; matrix op enabled by ALU_SEQ_MATR_EN
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 3,
  parameter int MATR_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp,
  input  logic [1:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic              flush_i,
  output logic              ready_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              ctrl_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              illegal_o
);

  localparam logic [CNT_W-1:0] MUL_CNT  = lat_preload(MUL_LAT);
  localparam logic [CNT_W-1:0] MATR_CNT = lat_preload(MATR_LAT);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               cvalid_q, cvalid_d;
  logic               illegal_q, illegal_d;

  logic [CODE_W-1:0]  dec_code;
  logic               dec_multi;
  logic               dec_illegal;
  logic               accept;
  logic [CNT_W-1:0]   cnt_load;

  alu_op_decode u_decode (
    .alu_op   (ALUOp),
    .funct7   (funct7),
    .funct3   (funct3),
    .code     (dec_code),
    .is_multi (dec_multi),
    .illegal  (dec_illegal)
  );

  // The decoder only yields the matrix code when that feature is built in,
  // so the matrix preload is otherwise never selected
  assign cnt_load = (dec_code == ALU_MATR) ? MATR_CNT : MUL_CNT;

  // A flush presented with an op drops it rather than accepting it
  assign accept = valid_i && !flush_i && (state_q != MULTI);

  // Next-state and next-register values for the sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    cvalid_d  = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE, SINGLE: begin
        if (accept) begin
          ctrl_d    = CTRL_W'(dec_code);
          cvalid_d  = 1'b1;
          illegal_d = dec_illegal;
          if (dec_multi) begin
            state_d = MULTI;
            cnt_d   = cnt_load;
          end else begin
            state_d = SINGLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULTI: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          ctrl_d  = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ctrl_d  = '0;
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      cvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      cvalid_q  <= cvalid_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs are forced low for the whole time reset is held; done is
  // suppressed when a flush lands on the final busy cycle
  assign ready_o      = (state_q != MULTI) && !rst;
  assign busy_o       = (state_q == MULTI) && !rst;
  assign done_o       = (state_q == MULTI) && (cnt_q == '0) && !flush_i && !rst;
  assign alu_ctrl_o   = rst ? '0 : ctrl_q;
  assign ctrl_valid_o = cvalid_q && !rst;
  assign illegal_o    = illegal_q && !rst;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic [1:0] ALUOp;
  logic [1:0] funct7;
  logic [2:0] funct3;
  logic       flush_i;
  logic       ready_o;
  logic [3:0] alu_ctrl_o;
  logic       ctrl_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       illegal_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] op;
    logic [1:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [3:0] code;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  alu_op_sequencer #(
    .CTRL_W   (4),
    .MUL_LAT  (3),
    .MATR_LAT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ALUOp        (ALUOp),
    .funct7       (funct7),
    .funct3       (funct3),
    .flush_i      (flush_i),
    .ready_o      (ready_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .ctrl_valid_o (ctrl_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] f7,
                       input logic [2:0] f3, input logic fl);
    valid_i = v;
    ALUOp   = op;
    funct7  = f7;
    funct3  = f3;
    flush_i = fl;
  endtask

  task automatic push(input logic [3:0] code, input logic ill);
    exp_t e;
    e.code = code;
    e.ill  = ill;
    sb.push_back(e);
  endtask

  // Scoreboard: every ctrl_valid_o must match the oldest expected op
  always @(negedge clk) begin
    if (!rst && ctrl_valid_o) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ctrl_valid", 32'(ctrl_valid_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_code", 32'(alu_ctrl_o), 32'(e.code));
        chk("sb_illegal", 32'(illegal_o), 32'(e.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    logic [3:0] b2b_code[3];
    logic [1:0] mop;
    logic [1:0] mf7;
    logic [2:0] mf3;
    int         mlat;
    int         flush_at;

    tbl[0]  = '{2'b00, 2'b00, 3'd0, 4'd2, 1'b0};
    tbl[1]  = '{2'b00, 2'b11, 3'd7, 4'd2, 1'b0};
    tbl[2]  = '{2'b01, 2'b00, 3'd0, 4'd5, 1'b0};
    tbl[3]  = '{2'b01, 2'b00, 3'd5, 4'd7, 1'b0};
    tbl[4]  = '{2'b01, 2'b00, 3'd2, 4'd0, 1'b1};
    tbl[5]  = '{2'b10, 2'b00, 3'd0, 4'd2, 1'b0};
    tbl[6]  = '{2'b10, 2'b00, 3'd4, 4'd4, 1'b0};
    tbl[7]  = '{2'b10, 2'b10, 3'd0, 4'd6, 1'b0};
    tbl[8]  = '{2'b10, 2'b11, 3'd0, 4'd0, 1'b1};
    tbl[9]  = '{2'b11, 2'b00, 3'd1, 4'd3, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 3'd0, 4'd2, 1'b0};
    tbl[11] = '{2'b11, 2'b00, 3'd7, 4'd0, 1'b1};
    tbl[12] = '{2'b11, 2'b01, 3'd1, 4'd3, 1'b0};

    // Reset with valid held high: nothing may come out
    rst = 1'b1;
    drive(1'b1, 2'b10, 2'b00, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(ready_o), 0);
      chk("rst_ctrl", 32'(alu_ctrl_o), 0);
      chk("rst_cvalid", 32'(ctrl_valid_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_illegal", 32'(illegal_o), 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_o), 1);
    chk("post_rst_cvalid", 32'(ctrl_valid_o), 0);
    tick();

    // Decode table, one op per cycle back-to-back
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].f7, tbl[i].f3, 1'b0);
      push(tbl[i].code, tbl[i].ill);
      @(negedge clk);
      chk("tbl_ready", 32'(ready_o), 1);
      chk("tbl_busy", 32'(busy_o), 0);
      tick();
    end
    drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    chk("tbl_last_illegal", 32'(illegal_o), 0);
    tick();
    @(negedge clk);
    chk("idle_cvalid", 32'(ctrl_valid_o), 0);
    tick();

    // add, xor, beq on consecutive cycles
    b2b_code = '{4'd2, 4'd4, 4'd5};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b1, 2'b10, 2'b00, 3'd0, 1'b0);
        1: drive(1'b1, 2'b10, 2'b00, 3'd4, 1'b0);
        2: drive(1'b1, 2'b01, 2'b00, 3'd0, 1'b0);
        default: drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
      endcase
      if (i < 3) push(b2b_code[i], 1'b0);
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_ctrl", 32'(alu_ctrl_o), 32'(b2b_code[i-1]));
        chk("b2b_cvalid", 32'(ctrl_valid_o), 1);
      end
      tick();
    end
    @(negedge clk);
    chk("b2b_back_idle_cvalid", 32'(ctrl_valid_o), 0);
    tick();

`ifndef ALU_SEQ_MATR_EN
    // Matrix encoding without the feature: illegal single-cycle op
    drive(1'b1, 2'b10, 2'b00, 3'd1, 1'b0);
    push(4'd0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    chk("matr_dis_illegal", 32'(illegal_o), 1);
    chk("matr_dis_busy", 32'(busy_o), 0);
    chk("matr_dis_ctrl", 32'(alu_ctrl_o), 0);
    tick();
`endif

    // Multiply with an add presented throughout the busy window
    drive(1'b1, 2'b10, 2'b01, 3'd0, 1'b0);
    push(4'd1, 1'b0);
    tick();
    drive(1'b1, 2'b10, 2'b00, 3'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
      @(negedge clk);
      chk("mul_busy", 32'(busy_o), (c <= 3) ? 1 : 0);
      chk("mul_ready", 32'(ready_o), (c <= 3) ? 0 : 1);
      chk("mul_done", 32'(done_o), (c == 3) ? 1 : 0);
      if (c <= 3) chk("mul_ctrl", 32'(alu_ctrl_o), 1);
      if (c == 4) chk("mul_no_accept", 32'(ctrl_valid_o), 0);
      tick();
    end

    // Flush during a multi-cycle op suppresses done and clears outputs
`ifdef ALU_SEQ_MATR_EN
    mop = 2'b10; mf7 = 2'b00; mf3 = 3'd1; mlat = 8; flush_at = 4;
`else
    mop = 2'b10; mf7 = 2'b01; mf3 = 3'd0; mlat = 3; flush_at = 3;
`endif
    drive(1'b1, mop, mf7, mf3, 1'b0);
    push((mlat == 8) ? 4'd8 : 4'd1, 1'b0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    for (int c = 1; c <= flush_at + 2; c++) begin
      flush_i = (c == flush_at);
      @(negedge clk);
      chk("flush_done", 32'(done_o), 0);
      chk("flush_busy", 32'(busy_o), (c <= flush_at) ? 1 : 0);
      if (c > flush_at) begin
        chk("flush_ctrl", 32'(alu_ctrl_o), 0);
        chk("flush_ready", 32'(ready_o), 1);
      end
      tick();
    end

    // Flush together with valid outside MULTI drops the op
    drive(1'b1, 2'b10, 2'b00, 3'd4, 1'b1);
    tick();
    drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    chk("flush_drop_cvalid", 32'(ctrl_valid_o), 0);
    tick();

    // Reset on the second multiply busy cycle
    drive(1'b1, 2'b10, 2'b01, 3'd0, 1'b0);
    push(4'd1, 1'b0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 3'd0, 1'b0);
    @(negedge clk);
    chk("rmid_busy1", 32'(busy_o), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_ready_in_rst", 32'(ready_o), 0);
    chk("rmid_busy_in_rst", 32'(busy_o), 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rmid_busy", 32'(busy_o), 0);
      chk("rmid_done", 32'(done_o), 0);
      chk("rmid_ctrl", 32'(alu_ctrl_o), 0);
      chk("rmid_cvalid", 32'(ctrl_valid_o), 0);
      chk("rmid_illegal", 32'(illegal_o), 0);
      chk("rmid_ready", 32'(ready_o), 1);
      tick();
    end

    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter CTRL_W, default 4: width of the ALU control code; SHALL be at least 4.
REQ-002 Parameter MUL_LAT, default 3: busy cycles for a multiply; legal range 1..15.
REQ-003 Parameter MATR_LAT, default 8: busy cycles for a matrix op; legal range 1..15.
REQ-004 clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 valid_i  in  1: a new operation is presented.
REQ-007 ALUOp  in  2: major op class (00 ld/st, 01 branch, 10 R-type, 11 I-type).
REQ-008 funct7  in  2: compressed funct7 bits.
REQ-009 funct3  in  3: funct3 field.
REQ-010 flush_i  in  1: abort the current operation.
REQ-011 ready_o  out  1: the block can accept an operation this cycle.
REQ-012 alu_ctrl_o  out  CTRL_W: registered ALU control code.
REQ-013 ctrl_valid_o  out  1: alu_ctrl_o is valid for one accepted operation.
REQ-014 busy_o  out  1: a multi-cycle op is in progress; the pipeline stalls.
REQ-015 done_o  out  1: one-cycle pulse on the final cycle of a multi-cycle op.
REQ-016 illegal_o  out  1: the accepted encoding is undefined.

Function
REQ-017 Decode table:
- ALUOp 00 -> 2.
- ALUOp 01: funct3 0 -> 5; funct3 5 -> 7.
- ALUOp 10, {funct7,funct3}: 00000 -> 2; 00100 -> 4; 10000 -> 6; 01000 -> 1; 00001 -> 8.
- ALUOp 11: funct3 1 -> 3; funct3 0 -> 2.
- Any other encoding -> 0, with illegal_o.
- Codes are zero-extended to CTRL_W.
REQ-018 FSM states SHALL be IDLE, SINGLE and MULTI.
REQ-019 Acceptance: an operation SHALL be accepted when valid_i && ready_o; ready_o = (state != MULTI) && !rst.
REQ-020 Single-cycle code (everything except 1 and 8):
- Next state SINGLE.
- ctrl_valid_o=1 for exactly one cycle, one cycle after acceptance.
- alu_ctrl_o takes the code; illegal_o is set as appropriate.
REQ-021 Back-to-back: from SINGLE, a new accept SHALL stay in SINGLE (one op per cycle); no accept SHALL return to IDLE with ctrl_valid_o=0.
REQ-022 Multi-cycle entry: code 1 or 8 SHALL move to MULTI and load a 4-bit down-counter with MUL_LAT-1 or MATR_LAT-1; ctrl_valid_o=1 in the first MULTI cycle.
REQ-023 In MULTI:
- busy_o=1 and ready_o=0.
- alu_ctrl_o is held and valid_i is ignored.
- The counter decrements each cycle.
REQ-024 Multi-cycle completion: when the counter is 0 in MULTI, done_o=1 in that cycle and the next state SHALL be IDLE. With LAT=1 the op SHALL spend exactly one cycle in MULTI with done_o=1.
REQ-025 Flush in MULTI: flush_i SHALL force IDLE next cycle with no done_o pulse, outputs cleared to 0.
REQ-026 Flush with valid_i: flush_i together with valid_i outside MULTI SHALL drop the operation (no accept).
REQ-027 done_o and ctrl_valid_o MAY both be high only when LAT=1.

Reset
REQ-028 While rst=1:
- State SHALL go to IDLE and the counter to 0.
- alu_ctrl_o, ctrl_valid_o, busy_o, done_o and illegal_o SHALL be 0.
- ready_o SHALL be 0.
REQ-029 rst asserted in MULTI SHALL abort the operation with no done_o pulse.

Configuration
REQ-030 Macro ALU_SEQ_MATR_EN: when defined, encoding 00001 under ALUOp 10 SHALL decode to code 8 as a MATR_LAT multi-cycle op. When undefined, the same encoding SHALL give code 0 with illegal_o=1 as a single-cycle op, and MATR_LAT SHALL be unused.

Structure
REQ-031 A shared package alu_seq_pkg SHALL hold:
- ALU code constants (ALU_NOP=0, MUL=1, ADD=2, SLL=3, XOR=4, BEQ=5, SUB=6, BGE=7, MATR=8).
- ALUOp class constants.
- The FSM state enum.
REQ-032 The decode table SHALL be one combinational sub-module alu_op_decode, outputting code, is_multi and illegal.

Verification
REQ-033 Reset: rst=1 for 2 cycles, valid_i=1 -> all outputs 0; ready_o=0 during reset and 1 in the cycle after rst falls.
REQ-034 Back-to-back add/xor/beq: ALUOp=10 00000, then 10 00100, then 01 funct3=0 -> alu_ctrl_o=2, 4, 5 on consecutive cycles, each with ctrl_valid_o=1.
REQ-035 Multiply, MUL_LAT=3: ALUOp=10 01000 -> busy_o high 3 cycles with alu_ctrl_o=1; done_o on the 3rd; ready_o low 3 cycles; a valid_i add during busy is not accepted.
REQ-036 Flush: matrix op, MATR_LAT=8, flush_i on the 4th busy cycle -> IDLE next cycle, done_o never asserted, busy_o=0.
REQ-037 Illegal encodings: ALUOp=01 funct3=2, then ALUOp=11 funct3=7 -> alu_ctrl_o=0 and illegal_o=1 for each; without ALU_SEQ_MATR_EN, 10 00001 -> illegal_o=1 and busy_o stays 0.
REQ-038 Reset mid-op: rst on the 2nd MUL busy cycle -> next cycle all outputs 0 and no done_o.
